rotate_sched: RTL and testbench

Sequencer for the three-digit rotating HEX display: drives the 2-bit rotation select of the three 3:1 two-bit character muxes automatically, instead of from SW[9:8]. Advances through the three rotation phases on a programmable prescaled tick, with run/pause, direction and single-step control. It sits between the board inputs (SW/KEY) and the existing mux/decoder datapath; its `sel` output replaces SW[9:8] at the mux select pins.

---
 rtl/hex_pkg.sv | 25 ++
 rtl/step_sync.sv | 28 ++
 rtl/rotate_sched.sv | 145 ++++++++++++++
 tb/tb_rotate_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// Shared types and constants for the rotating HEX display: sequencer FSM states,
// mux select codes per rotation phase, and the phase-to-one-hot decode.
package hex_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } sched_state_t;

    localparam logic [1:0] SEL_P0 = 2'b00;
    localparam logic [1:0] SEL_P1 = 2'b01;
    localparam logic [1:0] SEL_P2 = 2'b10;

    function automatic logic [2:0] phase_to_oh(input logic [1:0] phase);
        logic [2:0] oh;
        case (phase)
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/step_sync.sv
// Two-flop synchroniser for an asynchronous pushbutton followed by a rising-edge
// detector; a held button produces a single one-cycle pulse.
module step_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/rotate_sched.sv
// Rotation sequencer for the three-digit HEX display: steps the 3:1 mux select
// on a prescaled tick, with run/pause, direction and single-step control.
// Optional `blank` blink output is built when ROT_SCHED_BLINK_EN is defined.
module rotate_sched
    import hex_pkg::*;
#(
    parameter int PRESCALE = 25_000_000,
    parameter int CNT_W    = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             dir,
    input  logic [1:0]       speed,
    input  logic             step,
    output logic [1:0]       sel,
    output logic [2:0]       phase_oh,
    output logic             tick,
    output logic             running
`ifdef ROT_SCHED_BLINK_EN
    ,
    output logic             blank
`endif
);

    sched_state_t     state;
    sched_state_t     state_nx;
    logic             step_pulse;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] limit_m1;
    logic             expire;
    logic [1:0]       phase;
    logic [1:0]       phase_nx;
    logic             advance;

    step_sync u_step_sync (
        .clock (clock),
        .reset (reset),
        .din   (step),
        .pulse (step_pulse)
    );

    assign limit    = CNT_W'(PRESCALE) >> speed;
    assign limit_m1 = limit - CNT_W'(1);
    // >= rather than == so a mid-count speed increase expires on the next RUN cycle
    assign expire   = (cnt >= limit_m1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= STOP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            STOP: begin
                if (run) begin
                    state_nx = RUN;
                end else if (step_pulse) begin
                    state_nx = STEP;
                end
            end
            RUN: begin
                if (!run) begin
                    state_nx = STOP;
                end
            end
            STEP: begin
                state_nx = run ? RUN : STOP;
            end
            default: state_nx = STOP;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            tick    <= 1'b0;
            running <= 1'b0;
        end else begin
            if (state == RUN) begin
                cnt <= expire ? '0 : cnt + CNT_W'(1);
            end
            tick    <= (state == RUN) && expire;
            running <= (state_nx == RUN);
        end
    end

    // The registered tick drives the advance, so sel moves on the edge after tick
    assign advance = tick || (state == STEP);

    always_comb begin
        if (dir) begin
            phase_nx = (phase == 2'd0) ? 2'd2 : phase - 2'd1;
        end else begin
            phase_nx = (phase >= 2'd2) ? 2'd0 : phase + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= 2'd0;
        end else if (advance) begin
            phase <= phase_nx;
        end
    end

    always_comb begin
        case (phase)
            2'd1:    sel = SEL_P1;
            2'd2:    sel = SEL_P2;
            default: sel = SEL_P0;
        endcase
    end

    assign phase_oh = phase_to_oh(phase);

`ifdef ROT_SCHED_BLINK_EN
    localparam logic [CNT_W:0] BLINK_LAST = (CNT_W + 1)'(2 * PRESCALE - 1);

    logic [CNT_W:0] blink_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blank     <= 1'b0;
        end else if (state == STOP) begin
            if (blink_cnt >= BLINK_LAST) begin
                blink_cnt <= '0;
                blank     <= ~blank;
            end else begin
                blink_cnt <= blink_cnt + (CNT_W + 1)'(1);
            end
        end else begin
            blink_cnt <= '0;
            blank     <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rotate_sched.sv
// Directed bench for rotate_sched with PRESCALE=8; expected values worked out by hand.
module tb_rotate_sched;
    import hex_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run   = 1'b0;
    logic       dir   = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       step  = 1'b0;
    logic [1:0] sel;
    logic [2:0] phase_oh;
    logic       tick;
    logic       running;
`ifdef ROT_SCHED_BLINK_EN
    logic       blank;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    rotate_sched #(.PRESCALE(8), .CNT_W(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .dir      (dir),
        .speed    (speed),
        .step     (step),
        .sel      (sel),
        .phase_oh (phase_oh),
        .tick     (tick),
        .running  (running)
`ifdef ROT_SCHED_BLINK_EN
        ,
        .blank    (blank)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_sel", sel, 2'b00);
        check("rst_oh", phase_oh, 3'b001);
        check("rst_tick", tick, 1'b0);
        check("rst_running", running, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        bit found;
        n = 0;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            cycle();
            n++;
            if (tick) found = 1;
        end
        if (!found) check("tick_timeout", 0, 1);
    endtask

    task automatic press_step(input logic [1:0] prev, input logic [1:0] exp, input string tag);
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        cycle();
        check({tag, "_before"}, sel, prev);
        cycle();
        check(tag, sel, exp);
        check({tag, "_oh"}, phase_oh, phase_to_oh(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt_ticks;
        logic [1:0] fwd [3];
        logic [1:0] rev [3];
        logic [1:0] prev;
        fwd[0] = 2'b01; fwd[1] = 2'b10; fwd[2] = 2'b00;
        rev[0] = 2'b10; rev[1] = 2'b01; rev[2] = 2'b00;

        // forward, speed 0: tick every 8 cycles
        do_reset();
        run = 1'b1; dir = 1'b0; speed = 2'd0;
        cycle();
        check("run_entry", running, 1'b1);
        prev = 2'b00;
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            check("fwd_period", n, (i == 0) ? 8 : 7);
            check("fwd_sel_at_tick", sel, prev);
            cycle();
            check("fwd_tick_pulse", tick, 1'b0);
            check("fwd_sel", sel, fwd[i]);
            check("fwd_oh", phase_oh, phase_to_oh(fwd[i]));
            prev = fwd[i];
        end

        // reverse, speed 1: tick every 4 cycles
        run = 1'b0;
        do_reset();
        run = 1'b1; dir = 1'b1; speed = 2'd1;
        cycle();
        prev = 2'b00;
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            check("rev_period", n, (i == 0) ? 4 : 3);
            check("rev_sel_at_tick", sel, prev);
            cycle();
            check("rev_sel", sel, rev[i]);
            prev = rev[i];
        end

        // asynchronous reset while tick is high at phase 2
        run = 1'b0;
        do_reset();
        run = 1'b1; dir = 1'b0; speed = 2'd0;
        cycle();
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        check("pre_rst_sel", sel, 2'b10);
        check("pre_rst_tick", tick, 1'b1);
        reset = 1'b1;
        #2;
        check("async_rst_sel", sel, 2'b00);
        check("async_rst_oh", phase_oh, 3'b001);
        check("async_rst_tick", tick, 1'b0);
        check("async_rst_running", running, 1'b0);
        run = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // held step button while paused: one advance, 3 edges after first sample
        do_reset();
        run = 1'b0; dir = 1'b0; speed = 2'd0;
        step = 1'b1;
        cycle();
        check("hold_k0", sel, 2'b00);
        cycle();
        check("hold_k1", sel, 2'b00);
        cycle();
        check("hold_k2", sel, 2'b00);
        cycle();
        check("hold_k3", sel, 2'b01);
        repeat (16) cycle();
        check("hold_once", sel, 2'b01);
        check("hold_running", running, 1'b0);
        step = 1'b0;
        repeat (4) cycle();
        dir = 1'b1;
        press_step(2'b01, 2'b00, "step_rev");
        repeat (2) cycle();
        press_step(2'b00, 2'b10, "step_rev_wrap");

        // pause at cnt=5, resume finishes the period; step in RUN ignored
        do_reset();
        run = 1'b1; dir = 1'b0; speed = 2'd0;
        cycle();
        repeat (4) cycle();
        run = 1'b0;
        cycle();
        check("pause_running", running, 1'b0);
        cnt_ticks = 0;
        repeat (50) begin
            cycle();
            if (tick) cnt_ticks++;
        end
        check("pause_no_tick", cnt_ticks, 0);
        check("pause_sel", sel, 2'b00);
        run = 1'b1;
        cycle();
        check("resume_running", running, 1'b1);
        wait_tick(n);
        check("resume_period", n, 3);
        cycle();
        check("resume_sel", sel, 2'b01);
        step = 1'b1;
        cycle();
        step = 1'b0;
        wait_tick(n);
        check("run_step_period", n, 6);
        check("run_step_ignored", sel, 2'b01);
        cycle();
        check("run_step_next", sel, 2'b10);

        // speed 0->3 at cnt=6, then run falls with a tick pending
        run = 1'b0;
        do_reset();
        run = 1'b1; dir = 1'b0; speed = 2'd0;
        cycle();
        repeat (6) cycle();
        check("spd_no_tick", tick, 1'b0);
        speed = 2'd3;
        cycle();
        check("spd_tick0", tick, 1'b1);
        check("spd_sel0", sel, 2'b00);
        cycle();
        check("spd_tick1", tick, 1'b1);
        check("spd_sel1", sel, 2'b01);
        cycle();
        check("spd_tick2", tick, 1'b1);
        check("spd_sel2", sel, 2'b10);
        run = 1'b0;
        cycle();
        check("stop_tick", tick, 1'b1);
        check("stop_sel", sel, 2'b00);
        check("stop_running", running, 1'b0);
        cycle();
        check("stop_last_adv", sel, 2'b01);
        check("stop_tick_clr", tick, 1'b0);
        cycle();
        check("stop_hold", sel, 2'b01);

`ifdef ROT_SCHED_BLINK_EN
        do_reset();
        check("blank_rst", blank, 1'b0);
        n = 0;
        for (int i = 0; i < 40 && blank == 1'b0; i++) begin
            cycle();
            n++;
        end
        check("blank_on_period", n, 16);
        n = 0;
        for (int i = 0; i < 40 && blank == 1'b1; i++) begin
            cycle();
            n++;
        end
        check("blank_off_period", n, 16);
        run = 1'b1;
        cycle();
        check("blank_run", blank, 1'b0);
        run = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
